// File: rtl/kyber_pkg.sv
// Shared Kyber constants, zeta table, Barrett reduction and butterfly index maps.
// The INTT_SCALE_EN macro adds the SCALE state to the FSM encoding.
package kyber_pkg;

    localparam int unsigned COEF_W     = 16;
    localparam int unsigned SUM_W      = COEF_W + 1;
    localparam int unsigned NUM_BF     = 128;
    localparam int unsigned NUM_STAGES = 7;
    localparam int unsigned STAGE_W    = 3;
    localparam int unsigned IDX_W      = 8;
    localparam int unsigned ZIDX_W     = 7;

    localparam int KYBER_Q   = 3329;
    localparam int BARRETT_V = 20159;
    localparam int INTT_F    = 1441;
    localparam int QINV      = -3327;

    typedef logic signed [COEF_W-1:0] coef_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
`ifdef INTT_SCALE_EN
        ST_SCALE = 2'd2,
`endif
        ST_STAGE = 2'd1
    } state_e;

    // Montgomery-domain twiddles in the standard reference order
    localparam coef_t ZETAS [0:127] = '{
        -16'sd1044, -16'sd758,  -16'sd359,  -16'sd1517, 16'sd1493,  16'sd1422,  16'sd287,   16'sd202,
        -16'sd171,  16'sd622,   16'sd1577,  16'sd182,   16'sd962,   -16'sd1202, -16'sd1474, 16'sd1468,
        16'sd573,   -16'sd1325, 16'sd264,   16'sd383,   -16'sd829,  16'sd1458,  -16'sd1602, -16'sd130,
        -16'sd681,  16'sd1017,  16'sd732,   16'sd608,   -16'sd1542, 16'sd411,   -16'sd205,  -16'sd1571,
        16'sd1223,  16'sd652,   -16'sd552,  16'sd1015,  -16'sd1293, 16'sd1491,  -16'sd282,  -16'sd1544,
        16'sd516,   -16'sd8,    -16'sd320,  -16'sd666,  -16'sd1618, -16'sd1162, 16'sd126,   16'sd1469,
        -16'sd853,  -16'sd90,   -16'sd271,  16'sd830,   16'sd107,   -16'sd1421, -16'sd247,  -16'sd951,
        -16'sd398,  16'sd961,   -16'sd1508, -16'sd725,  16'sd448,   -16'sd1065, 16'sd677,   -16'sd1275,
        -16'sd1103, 16'sd430,   16'sd555,   16'sd843,   -16'sd1251, 16'sd871,   16'sd1550,  16'sd105,
        16'sd422,   16'sd587,   16'sd177,   -16'sd235,  -16'sd291,  -16'sd460,  16'sd1574,  16'sd1653,
        -16'sd246,  16'sd778,   16'sd1159,  -16'sd147,  -16'sd777,  16'sd1483,  -16'sd602,  16'sd1119,
        -16'sd1590, 16'sd644,   -16'sd872,  16'sd349,   16'sd418,   16'sd329,   -16'sd156,  -16'sd75,
        16'sd817,   16'sd1097,  16'sd603,   16'sd610,   16'sd1322,  -16'sd1285, -16'sd1465, 16'sd384,
        -16'sd1215, -16'sd136,  16'sd1218,  -16'sd1335, -16'sd874,  16'sd220,   -16'sd1187, -16'sd1659,
        -16'sd1185, -16'sd1530, -16'sd1278, 16'sd794,   -16'sd1510, -16'sd854,  -16'sd870,  16'sd478,
        -16'sd108,  -16'sd308,  16'sd996,   16'sd991,   16'sd958,   -16'sd1460, 16'sd1522,  16'sd1628
    };

    function automatic coef_t barrett_reduce(input logic signed [SUM_W-1:0] x);
        logic signed [31:0] xw;
        logic signed [31:0] t;
        xw = 32'(x);
        t  = (32'(BARRETT_V) * xw + 32'sd33554432) >>> 26;
        return COEF_W'(xw - t * 32'(KYBER_Q));
    endfunction

    // Upper operand index of butterfly i in stage s
    function automatic logic [IDX_W-1:0] bf_top(input int unsigned i, input int unsigned s);
        return IDX_W'((i >> (s + 1)) * (4 << s) + (i & ((2 << s) - 1)));
    endfunction

    function automatic logic [IDX_W-1:0] bf_bot(input int unsigned i, input int unsigned s);
        return IDX_W'(32'(bf_top(i, s)) + (2 << s));
    endfunction

    function automatic logic [ZIDX_W-1:0] bf_zeta(input int unsigned i, input int unsigned s);
        return ZIDX_W'((128 >> s) - 1 - (i >> (s + 1)));
    endfunction

endpackage

// File: rtl/fqmul.sv
// Montgomery multiplier: r = a*b*2^-16 mod q, result in (-q, q).
module fqmul
    import kyber_pkg::*;
#(
    parameter int unsigned Q = 3329
)(
    input  logic signed [COEF_W-1:0] a_i,
    input  logic signed [COEF_W-1:0] b_i,
    output logic signed [COEF_W-1:0] r_o
);

    logic signed [31:0]       p_c;
    logic        [COEF_W-1:0] t_u_c;
    logic signed [COEF_W-1:0] t_c;
    logic signed [31:0]       d_c;

    assign p_c   = 32'(a_i) * 32'(b_i);
    assign t_u_c = p_c[COEF_W-1:0] * COEF_W'(QINV);
    assign t_c   = signed'(t_u_c);
    // low 16 bits of d_c are zero by construction, so the shift is exact
    assign d_c   = p_c - 32'(t_c) * 32'(Q);
    assign r_o   = COEF_W'(d_c >>> 16);

endmodule

// File: rtl/gentleman_sande.sv
// Gentleman-Sande butterfly: out0 = barrett(a+b), out1 = fqmul(zeta, b-a).
module gentleman_sande
    import kyber_pkg::*;
#(
    parameter int unsigned Q = 3329
)(
    input  logic signed [COEF_W-1:0] a,
    input  logic signed [COEF_W-1:0] b,
    input  logic signed [COEF_W-1:0] zeta,
    output logic signed [COEF_W-1:0] out0,
    output logic signed [COEF_W-1:0] out1
);

    logic signed [SUM_W-1:0] sum_c;
    logic signed [SUM_W-1:0] diff_c;

    assign sum_c  = SUM_W'(a) + SUM_W'(b);
    assign diff_c = SUM_W'(b) - SUM_W'(a);
    assign out0   = barrett_reduce(sum_c);

    fqmul #(.Q(Q)) u_mul (
        .a_i (zeta),
        .b_i (COEF_W'(diff_c)),
        .r_o (out1)
    );

endmodule

// File: rtl/intt.sv
// Kyber inverse NTT, one Gentleman-Sande stage per clock over 128 butterflies.
// Define INTT_SCALE_EN to add the final Montgomery scaling state (x1441).
module intt
    import kyber_pkg::*;
#(
    parameter int unsigned NUM_COEF = 256,
    parameter int unsigned KYBER_Q  = 3329
)(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enable,
    input  logic signed [COEF_W-1:0] in  [0:NUM_COEF-1],
    output logic signed [COEF_W-1:0] out [0:NUM_COEF-1],
    output logic                     valid,
    output logic                     busy
);

    state_e             state_q, state_d;
    logic [STAGE_W-1:0] stage_q, stage_d;
    coef_t              buf_q [0:NUM_COEF-1];
    coef_t              buf_d [0:NUM_COEF-1];
    coef_t              out_q [0:NUM_COEF-1];
    coef_t              out_d [0:NUM_COEF-1];
    logic               valid_q, valid_d;
    logic               busy_q, busy_d;

    coef_t bf_o0 [0:NUM_BF-1];
    coef_t bf_o1 [0:NUM_BF-1];

    // Per-butterfly operand/zeta muxes, one leg per stage
    for (genvar gi = 0; gi < NUM_BF; gi++) begin : g_bf
        coef_t a_c, b_c, z_c;

        always_comb begin
            a_c = buf_q[bf_top(gi, 0)];
            b_c = buf_q[bf_bot(gi, 0)];
            z_c = ZETAS[bf_zeta(gi, 0)];
            for (int s = 1; s < NUM_STAGES; s++) begin
                if (stage_q == STAGE_W'(s)) begin
                    a_c = buf_q[bf_top(gi, s)];
                    b_c = buf_q[bf_bot(gi, s)];
                    z_c = ZETAS[bf_zeta(gi, s)];
                end
            end
        end

        gentleman_sande #(.Q(KYBER_Q)) u_gs (
            .a    (a_c),
            .b    (b_c),
            .zeta (z_c),
            .out0 (bf_o0[gi]),
            .out1 (bf_o1[gi])
        );
    end

`ifdef INTT_SCALE_EN
    coef_t scl_c [0:NUM_COEF-1];

    for (genvar gk = 0; gk < NUM_COEF; gk++) begin : g_scl
        fqmul #(.Q(KYBER_Q)) u_scl (
            .a_i (buf_q[gk]),
            .b_i (COEF_W'(INTT_F)),
            .r_o (scl_c[gk])
        );
    end
`endif

    always_comb begin
        state_d = state_q;
        stage_d = stage_q;
        buf_d   = buf_q;
        out_d   = out_q;
        valid_d = 1'b0;
        busy_d  = busy_q;
        unique case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    buf_d   = in;
                    stage_d = '0;
                    busy_d  = 1'b1;
                    state_d = ST_STAGE;
                end
            end
            ST_STAGE: begin
                for (int s = 0; s < NUM_STAGES; s++) begin
                    if (stage_q == STAGE_W'(s)) begin
                        for (int i = 0; i < NUM_BF; i++) begin
                            buf_d[bf_top(i, s)] = bf_o0[i];
                            buf_d[bf_bot(i, s)] = bf_o1[i];
                        end
                    end
                end
                stage_d = stage_q + STAGE_W'(1);
                if (stage_q == STAGE_W'(NUM_STAGES - 1)) begin
                    stage_d = '0;
`ifdef INTT_SCALE_EN
                    state_d = ST_SCALE;
`else
                    for (int i = 0; i < NUM_BF; i++) begin
                        out_d[bf_top(i, NUM_STAGES - 1)] = bf_o0[i];
                        out_d[bf_bot(i, NUM_STAGES - 1)] = bf_o1[i];
                    end
                    valid_d = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
`endif
                end
            end
`ifdef INTT_SCALE_EN
            ST_SCALE: begin
                out_d   = scl_c;
                valid_d = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            stage_q <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            for (int k = 0; k < NUM_COEF; k++) begin
                buf_q[k] <= '0;
                out_q[k] <= '0;
            end
        end else begin
            state_q <= state_d;
            stage_q <= stage_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            buf_q   <= buf_d;
            out_q   <= out_d;
        end
    end

    assign out   = out_q;
    assign valid = valid_q;
    assign busy  = busy_q;

endmodule

// File: tb/tb_intt.sv
// Self-checking bench for intt against a loop-based reference of invntt_tomont.
// Honours INTT_SCALE_EN for latency and output scaling.
module tb_intt;

    localparam int N = 256;
    localparam int Q = 3329;
`ifdef INTT_SCALE_EN
    localparam int LAT = 8;
`else
    localparam int LAT = 7;
`endif

    typedef int poly_t [0:N-1];

    logic clk = 1'b0;
    logic rst;
    logic enable;
    logic signed [15:0] in_v  [0:N-1];
    logic signed [15:0] out_v [0:N-1];
    logic valid;
    logic busy;

    int checks   = 0;
    int failures = 0;

    int zt [0:127] = '{
        -1044, -758, -359, -1517, 1493, 1422, 287, 202, -171, 622, 1577, 182, 962, -1202, -1474, 1468,
        573, -1325, 264, 383, -829, 1458, -1602, -130, -681, 1017, 732, 608, -1542, 411, -205, -1571,
        1223, 652, -552, 1015, -1293, 1491, -282, -1544, 516, -8, -320, -666, -1618, -1162, 126, 1469,
        -853, -90, -271, 830, 107, -1421, -247, -951, -398, 961, -1508, -725, 448, -1065, 677, -1275,
        -1103, 430, 555, 843, -1251, 871, 1550, 105, 422, 587, 177, -235, -291, -460, 1574, 1653,
        -246, 778, 1159, -147, -777, 1483, -602, 1119, -1590, 644, -872, 349, 418, 329, -156, -75,
        817, 1097, 603, 610, 1322, -1285, -1465, 384, -1215, -136, 1218, -1335, -874, 220, -1187, -1659,
        -1185, -1530, -1278, 794, -1510, -854, -870, 478, -108, -308, 996, 991, 958, -1460, 1522, 1628
    };

    intt dut (
        .clk    (clk),
        .rst    (rst),
        .enable (enable),
        .in     (in_v),
        .out    (out_v),
        .valid  (valid),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int m_barrett(input int a);
        int t;
        t = ((20159 * a + (1 << 25)) >>> 26) * Q;
        return a - t;
    endfunction

    function automatic int m_fqmul(input int a, input int b);
        int p;
        shortint t;
        p = a * b;
        t = shortint'(p * -3327);
        return (p - int'(t) * Q) >>> 16;
    endfunction

    function automatic int modq(input int x);
        return ((x % Q) + Q) % Q;
    endfunction

    function automatic int modpow(input int base, input int e);
        int r;
        r = 1;
        for (int i = 0; i < e; i++) r = (r * base) % Q;
        return r;
    endfunction

    // Reference invntt_tomont, written as the in-place C loop with a running zeta index
    function automatic void ref_intt(input poly_t a, output poly_t r);
        int k;
        int t;
        int zeta;
        r = a;
        k = 127;
        for (int len = 2; len <= 128; len = len * 2) begin
            for (int start = 0; start < N; start = start + 2 * len) begin
                zeta = zt[k];
                k--;
                for (int j = start; j < start + len; j++) begin
                    t = r[j];
                    r[j] = m_barrett(t + r[j + len]);
                    r[j + len] = int'(shortint'(r[j + len] - t));
                    r[j + len] = m_fqmul(zeta, r[j + len]);
                end
            end
        end
`ifdef INTT_SCALE_EN
        for (int i = 0; i < N; i++) r[i] = m_fqmul(r[i], 1441);
`endif
    endfunction

    // Reference forward ntt followed by poly_reduce
    function automatic void ref_ntt(input poly_t a, output poly_t r);
        int k;
        int t;
        int zeta;
        r = a;
        k = 1;
        for (int len = 128; len >= 2; len = len / 2) begin
            for (int start = 0; start < N; start = start + 2 * len) begin
                zeta = zt[k];
                k++;
                for (int j = start; j < start + len; j++) begin
                    t = m_fqmul(zeta, r[j + len]);
                    r[j + len] = r[j] - t;
                    r[j] = r[j] + t;
                end
            end
        end
        for (int i = 0; i < N; i++) r[i] = m_barrett(r[i]);
    endfunction

    task automatic load(input poly_t a);
        for (int i = 0; i < N; i++) in_v[i] = 16'(a[i]);
    endtask

    task automatic start(input poly_t a);
        load(a);
        enable = 1'b1;
        @(posedge clk); #1;
        enable = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (valid !== 1'b1 && lat < 4 * LAT) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic count_valid(input int cycles, output int pulses);
        pulses = 0;
        for (int c = 0; c < cycles; c++) begin
            @(posedge clk); #1;
            if (valid === 1'b1) pulses++;
        end
    endtask

    task automatic cmp_poly(input string tag, input poly_t e);
        int bad;
        int oor;
        bad = -1;
        oor = 0;
        for (int i = 0; i < N; i++) begin
            if (bad < 0 && int'(out_v[i]) !== e[i]) bad = i;
            if (int'(out_v[i]) >= Q || int'(out_v[i]) <= -Q) oor++;
        end
        if (bad < 0) bad = 0;
        chk($sformatf("%s[%0d]", tag, bad), int'(out_v[bad]), e[bad]);
        chk({tag, "_range"}, oor, 0);
    endtask

    function automatic void rand_poly(output poly_t a);
        for (int i = 0; i < N; i++) a[i] = int'($urandom_range(2 * Q - 2)) - (Q - 1);
    endfunction

    initial begin
        poly_t z, a, b, c, e, d;
        int lat;
        int pulses;
        int nz;
        int rt;

        for (int i = 0; i < N; i++) z[i] = 0;
        rst = 1'b1;
        enable = 1'b0;
        load(z);
        repeat (3) @(posedge clk);
        #1;
        chk("reset_valid", int'(valid), 0);
        chk("reset_busy", int'(busy), 0);
        cmp_poly("reset_out", z);
        rst = 1'b0;
        @(posedge clk); #1;

        // all-zero polynomial: latency, pulse width, busy timing
        start(z);
        chk("zero_busy_cap", int'(busy), 1);
        wait_valid(lat);
        chk("zero_lat", lat, LAT);
        chk("zero_busy_done", int'(busy), 0);
        cmp_poly("zero_out", z);
        @(posedge clk); #1;
        chk("zero_valid_width", int'(valid), 0);

        // random polynomials, first two at the coefficient extremes
        for (int p = 0; p < 100; p++) begin
            if (p == 0) for (int i = 0; i < N; i++) a[i] = Q - 1;
            else if (p == 1) for (int i = 0; i < N; i++) a[i] = -(Q - 1);
            else rand_poly(a);
            ref_intt(a, e);
            start(a);
            wait_valid(lat);
            chk($sformatf("rand%0d_lat", p), lat, LAT);
            cmp_poly($sformatf("rand%0d", p), e);
        end

        // reset during stage 3 aborts with no valid and zeroed outputs
        rand_poly(a);
        start(a);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_busy", int'(busy), 0);
        chk("abort_valid", int'(valid), 0);
        cmp_poly("abort_out", z);
        count_valid(LAT + 4, pulses);
        chk("abort_no_valid", pulses, 0);
        rand_poly(a);
        ref_intt(a, e);
        start(a);
        wait_valid(lat);
        chk("after_abort_lat", lat, LAT);
        cmp_poly("after_abort", e);

        // enable re-pulsed at stage 2 with other data is ignored
        rand_poly(a);
        rand_poly(b);
        ref_intt(a, e);
        start(a);
        repeat (2) @(posedge clk);
        #1;
        load(b);
        enable = 1'b1;
        @(posedge clk); #1;
        enable = 1'b0;
        wait_valid(lat);
        chk("repulse_lat", lat + 3, LAT);
        cmp_poly("repulse", e);

        // enable held high: back-to-back transforms every LAT+1 edges
        rand_poly(c);
        ref_intt(c, e);
        load(c);
        enable = 1'b1;
        @(posedge clk); #1;
        wait_valid(lat);
        chk("held_lat1", lat, LAT);
        cmp_poly("held1", e);
        lat = 1;
        @(posedge clk); #1;
        while (valid !== 1'b1 && lat < 4 * LAT) begin
            @(posedge clk); #1;
            lat++;
        end
        enable = 1'b0;
        chk("held_period", lat, LAT + 1);
        cmp_poly("held2", e);
        @(posedge clk); #1;

        // rst and enable together: nothing captured, outputs cleared
        rand_poly(a);
        load(a);
        rst = 1'b1;
        enable = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        enable = 1'b0;
        chk("rst_en_busy", int'(busy), 0);
        cmp_poly("rst_en_out", z);
        count_valid(LAT + 4, pulses);
        chk("rst_en_no_valid", pulses, 0);

        // round trip of a delta through ntt then intt
        for (int i = 0; i < N; i++) d[i] = 0;
        d[0] = 1;
        ref_ntt(d, a);
`ifdef INTT_SCALE_EN
        rt = 2285;
`else
        rt = (((2285 * 2285) % Q) * modpow(1441, Q - 2)) % Q;
`endif
        start(a);
        wait_valid(lat);
        chk("rt_lat", lat, LAT);
        chk("rt_out0_mod", modq(int'(out_v[0])), rt);
        nz = 0;
        for (int i = 1; i < N; i++) if (modq(int'(out_v[i])) != 0) nz++;
        chk("rt_others_zero", nz, 0);
        ref_intt(a, e);
        cmp_poly("rt_exact", e);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
